// File: rtl/mem_io_pkg.sv
// ---------------------------------------------------------------------------
// mem_io_pkg
// Shared decode constants and types for the CPU-side memory/IO responder.
//   IO_BASE / IO_MASK : the 0x30000 IO window inside the 18-bit decoded space
//   RAM_TOP           : first byte address above the RAM
//   IO_PORT_UART      : low offset bits of the UART data port (0x30000)
//   IO_PORT_CLK(_MASK): offset pattern 3'b1xx selecting the cycle counter bytes
//   byte_t            : one bus byte
//   ptrWidth()        : FIFO pointer width, one extra wrap bit over the index
// ---------------------------------------------------------------------------
package mem_io_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [17:0] IO_BASE          = 18'h30000;
    localparam logic [17:0] IO_MASK          = 18'h30000;
    localparam logic [17:0] RAM_TOP          = 18'h20000;
    localparam logic [1:0]  IO_PORT_UART     = 2'b00;
    localparam logic [2:0]  IO_PORT_CLK      = 3'b100;
    localparam logic [2:0]  IO_PORT_CLK_MASK = 3'b100;

    // The extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO with wrap-bit pointers, used for UART TX and RX.
//   clock_i      : clock
//   resetN_i     : synchronous active-low reset, empties the FIFO
//   push_i       : write request; pushData_i is stored when accepted
//   pop_i        : read request; head advances when accepted
//   head_o       : oldest entry (stale when empty)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   count_o      : current occupancy
//   countNext_o  : occupancy after this edge's accepted push/pop
// ---------------------------------------------------------------------------
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clock_i,
    input  logic                   resetN_i,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      pushData_i,
    input  logic                   pop_i,
    output logic [DATA_W-1:0]      head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] countNext_o
);

    localparam int PTR_W = ptrWidth(DEPTH);

    logic [DATA_W-1:0] storeQ [DEPTH];
    logic [PTR_W-1:0]  wrPtrQ;
    logic [PTR_W-1:0]  rdPtrQ;
    logic              pushOk;
    logic              popOk;

    // Full when the index bits agree but the wrap bits differ. A push into a
    // full FIFO is still accepted when the head leaves in the same cycle.
    assign empty_o     = (wrPtrQ == rdPtrQ);
    assign full_o      = (wrPtrQ[PTR_W-1] != rdPtrQ[PTR_W-1]) &&
                         (wrPtrQ[PTR_W-2:0] == rdPtrQ[PTR_W-2:0]);
    assign popOk       = pop_i && !empty_o;
    assign pushOk      = push_i && (!full_o || popOk);
    assign count_o     = wrPtrQ - rdPtrQ;
    assign countNext_o = count_o + PTR_W'(pushOk) - PTR_W'(popOk);
    assign head_o      = storeQ[rdPtrQ[PTR_W-2:0]];

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clock_i) begin
        if (pushOk) begin
            storeQ[wrPtrQ[PTR_W-2:0]] <= pushData_i;
        end
    end

    // Pointer update; reset empties the FIFO regardless of pending traffic.
    always_ff @(posedge clock_i) begin
        if (!resetN_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else begin
            if (pushOk) begin
                wrPtrQ <= wrPtrQ + PTR_W'(1);
            end
            if (popOk) begin
                rdPtrQ <= rdPtrQ + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Responder end of the CPU byte bus: 128 KB RAM, UART TX/RX FIFOs and a
// free-running 32-bit cycle counter, all behind one address decoder.
//   clk_in         : clock
//   rst_in         : synchronous active-low reset
//   mem_a          : byte address, only [17:0] decoded
//   mem_wr         : 1 = write, 0 = read; every cycle is a request
//   mem_dout       : write data from the CPU
//   mem_din        : read data, valid the cycle after the request
//   io_buffer_full : TX FIFO has fewer than FULL_MARGIN free slots
//   tx_valid/tx_data/tx_ready : TX byte stream towards the UART
//   rx_valid/rx_data          : RX bytes arriving from the UART
//   program_done   : sticky stop flag set by a write to 0x30004
// ---------------------------------------------------------------------------
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        program_done
);

    localparam int TX_PTR_W = ptrWidth(TX_DEPTH);
    localparam int RX_PTR_W = ptrWidth(RX_DEPTH);

    byte_t                ram [2**RAM_ADDR_W];
    byte_t                ramRdQ;
    logic                 ramSelQ;
    byte_t                ioDataQ;
    byte_t                ioDataD;
    logic [31:0]          cycleQ;
    logic                 programDoneQ;
    logic                 ioBufferFullQ;
    logic                 ioBufferFullD;
    logic                 txOverflowQ;

    logic                 isRam;
    logic                 isIo;
    logic                 ioUart;
    logic                 ioClk;
    logic                 stopWr;
    logic [RAM_ADDR_W-1:0] ramIdx;

    logic                 txPush;
    byte_t                txPushData;
    byte_t                txHead;
    logic                 txFull;
    logic                 txEmpty;
    logic [TX_PTR_W-1:0]  txCount;
    logic [TX_PTR_W-1:0]  txCountNext;

    logic                 rxPop;
    byte_t                rxHead;
    logic                 rxFull;
    logic                 rxEmpty;
    logic [RX_PTR_W-1:0]  rxCount;
    logic [RX_PTR_W-1:0]  rxCountNext;

    logic                 unusedSink;

    // Address decode. Bits above 17 are ignored, so the map repeats every
    // 256 KB. The 0x20000-0x2FFFF hole neither reads nor writes anything.
    assign ramIdx = mem_a[RAM_ADDR_W-1:0];
    assign isRam  = (mem_a[17:0] < RAM_TOP);
    assign isIo   = ((mem_a[17:0] & IO_MASK) == IO_BASE);
    assign ioUart = isIo && (mem_a[15:2] == '0) && (mem_a[1:0] == IO_PORT_UART);
    assign ioClk  = isIo && (mem_a[15:3] == '0) &&
                    ((mem_a[2:0] & IO_PORT_CLK_MASK) == IO_PORT_CLK);
    assign stopWr = mem_wr && ioClk && (mem_a[1:0] == 2'b00);

    // A zero byte to the UART port is treated as "nothing to send"; the stop
    // write instead injects a zero byte so the host sees the end marker.
    assign txPush     = (mem_wr && ioUart && (mem_dout != 8'h00)) || stopWr;
    assign txPushData = stopWr ? 8'h00 : mem_dout;
    assign rxPop      = !mem_wr && ioUart;

    byte_fifo #(
        .DEPTH  (TX_DEPTH),
        .DATA_W (8)
    ) txFifo (
        .clock_i     (clk_in),
        .resetN_i    (rst_in),
        .push_i      (txPush),
        .pushData_i  (txPushData),
        .pop_i       (tx_ready),
        .head_o      (txHead),
        .full_o      (txFull),
        .empty_o     (txEmpty),
        .count_o     (txCount),
        .countNext_o (txCountNext)
    );

    byte_fifo #(
        .DEPTH  (RX_DEPTH),
        .DATA_W (8)
    ) rxFifo (
        .clock_i     (clk_in),
        .resetN_i    (rst_in),
        .push_i      (rx_valid),
        .pushData_i  (rx_data),
        .pop_i       (rxPop),
        .head_o      (rxHead),
        .full_o      (rxFull),
        .empty_o     (rxEmpty),
        .count_o     (rxCount),
        .countNext_o (rxCountNext)
    );

    // RAM port kept free of reset so it maps onto block RAM. Reading the old
    // contents on a write cycle is harmless because writes never return data.
    always_ff @(posedge clk_in) begin
        if (mem_wr && isRam) begin
            ram[ramIdx] <= mem_dout;
        end
        ramRdQ <= ram[ramIdx];
    end

    // IO read data captured at the request edge: RX head (only when there is
    // one) or the addressed counter byte as it stood before this edge.
    always_comb begin
        ioDataD = 8'h00;
        if (!mem_wr) begin
            if (ioUart && !rxEmpty) begin
                ioDataD = rxHead;
            end else if (ioClk) begin
                ioDataD = cycleQ[{mem_a[1:0], 3'b000} +: 8];
            end
        end
    end

    // Early warning uses the post-edge occupancy so a write already in
    // flight from the CPU still finds a free slot.
    assign ioBufferFullD = (TX_DEPTH - int'(txCountNext)) < FULL_MARGIN;

    // Control and status registers; reset also forces mem_din to zero by
    // deselecting the RAM path and clearing the IO data register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cycleQ        <= '0;
            ramSelQ       <= 1'b0;
            ioDataQ       <= 8'h00;
            programDoneQ  <= 1'b0;
            ioBufferFullQ <= 1'b0;
            txOverflowQ   <= 1'b0;
        end else begin
            cycleQ        <= cycleQ + 32'd1;
            ramSelQ       <= isRam && !mem_wr;
            ioDataQ       <= ioDataD;
            ioBufferFullQ <= ioBufferFullD;
            if (stopWr) begin
                programDoneQ <= 1'b1;
            end
            if (txPush && txFull && !tx_ready) begin
                txOverflowQ <= 1'b1;
            end
        end
    end

    assign mem_din        = ramSelQ ? ramRdQ : ioDataQ;
    assign tx_valid       = !txEmpty;
    assign tx_data        = txEmpty ? 8'h00 : txHead;
    assign io_buffer_full = ioBufferFullQ;
    assign program_done   = programDoneQ;

    // Debug-only and decode-ignored bits collected in one place.
    assign unusedSink = ^{mem_a[31:18], txOverflowQ, txCount, rxFull,
                          rxCount, rxCountNext};

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Scoreboard bench for mem_io_responder: stimulus pushes expected read data
// and expected TX bytes into queues, a negedge monitor pops and compares
// whenever a read response is due or a TX handshake occurs.
// ---------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam logic [31:0] IDLE_ADDR = 32'h0002_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a  = IDLE_ADDR;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        program_done;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  rdExpQ [$];
    logic [7:0]  txExpQ [$];
    logic        reqRead  = 1'b0;
    logic        rspDue   = 1'b0;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .program_done   (program_done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one bus request for exactly one cycle and returns 1 unit after
    // the edge that sampled it. Checked reads queue their expected byte.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                                 input logic [7:0] data, input logic check,
                                 input logic [7:0] expData);
        mem_a    = addr;
        mem_wr   = wr;
        mem_dout = data;
        reqRead  = !wr && check;
        if (!wr && check) begin
            rdExpQ.push_back(expData);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        applyStimulus(IDLE_ADDR, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic writeTx(input logic [31:0] addr, input logic [7:0] data,
                           input logic expectOut);
        if (expectOut) begin
            txExpQ.push_back(data);
        end
        applyStimulus(addr, 1'b1, data, 1'b0, 8'h00);
    endtask

    // A read issued before an edge has its response due after that edge.
    always @(posedge clk_in) rspDue <= reqRead;

    // Monitor: compares read data one cycle after each checked read and every
    // byte the UART side actually takes.
    always @(negedge clk_in) begin
        if (rspDue) begin
            if (rdExpQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL read response with empty queue: got 0x%0h, expected none", mem_din);
            end else begin
                checkOutput("mem_din", {24'h0, mem_din}, {24'h0, rdExpQ.pop_front()});
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (txExpQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected tx byte: got 0x%0h, expected none", tx_data);
            end else begin
                checkOutput("tx_data", {24'h0, tx_data}, {24'h0, txExpQ.pop_front()});
            end
        end
    end

    // Watchdog against a stuck simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset and reset values.
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset mem_din", {24'h0, mem_din}, 32'h0);
        checkOutput("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("reset tx_data", {24'h0, tx_data}, 32'h0);
        checkOutput("reset program_done", {31'h0, program_done}, 32'h0);
        checkOutput("reset io_buffer_full", {31'h0, io_buffer_full}, 32'h0);
        rst_in = 1'b1;

        // RAM: write-then-read, hole reads, dropped hole writes, aliasing.
        $display("[TB] RAM test");
        applyStimulus(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
        applyStimulus(32'h0002_0000, 1'b0, 8'h00, 1'b1, 8'h00);
        applyStimulus(32'h0001_FFFF, 1'b1, 8'h5A, 1'b0, 8'h00);
        applyStimulus(32'h0002_0010, 1'b1, 8'hEE, 1'b0, 8'h00);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
        applyStimulus(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h5A);
        applyStimulus(32'hFFFC_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
        idle();

        // UART out: zero bytes and stray IO writes produce nothing.
        $display("[TB] UART out test");
        tx_ready = 1'b1;
        writeTx(32'h0003_0000, 8'h48, 1'b1);
        writeTx(32'h0003_0000, 8'h00, 1'b0);
        writeTx(32'h0003_0000, 8'h69, 1'b1);
        writeTx(32'h0003_0008, 8'h55, 1'b0);
        writeTx(32'h0003_0005, 8'h77, 1'b0);
        repeat (4) idle();
        checkOutput("uart drained", txExpQ.size(), 32'h0);
        checkOutput("program_done after stray writes", {31'h0, program_done}, 32'h0);

        // Backpressure: threshold at 15 entries, full drop, push+pop on full.
        $display("[TB] backpressure test");
        tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            writeTx(32'h0003_0000, 8'h41 + 8'(i), 1'b1);
        end
        checkOutput("io_buffer_full at 14", {31'h0, io_buffer_full}, 32'h0);
        writeTx(32'h0003_0000, 8'h4F, 1'b1);
        checkOutput("io_buffer_full at 15", {31'h0, io_buffer_full}, 32'h1);
        writeTx(32'h0003_0000, 8'h50, 1'b1);
        writeTx(32'h0003_0000, 8'h99, 1'b0);
        checkOutput("io_buffer_full when full", {31'h0, io_buffer_full}, 32'h1);
        checkOutput("tx head while stalled", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        writeTx(32'h0003_0000, 8'h7E, 1'b1);
        repeat (20) idle();
        checkOutput("backpressure drained", txExpQ.size(), 32'h0);
        checkOutput("io_buffer_full after drain", {31'h0, io_buffer_full}, 32'h0);

        // Cycle counter: known distance from reset release.
        $display("[TB] clock test");
        tx_ready = 1'b0;
        rst_in = 1'b0;
        idle();
        idle();
        rst_in = 1'b1;
        repeat (16'h1234) @(posedge clk_in);
        #1;
        applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h34);
        applyStimulus(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'h12);
        applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h36);
        applyStimulus(32'h0003_0006, 1'b0, 8'h00, 1'b1, 8'h00);
        idle();

        // RX: ordering, empty read, simultaneous push/pop, overflow drop.
        $display("[TB] RX test");
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idle();
        rx_data  = 8'h32;
        idle();
        rx_valid = 1'b0;
        applyStimulus(32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h00);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h31);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h32);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        idle();
        rx_data  = 8'h34;
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h33);
        rx_valid = 1'b0;
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h34);
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'h60 + 8'(i);
            idle();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h60 + 8'(i));
        end
        applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
        idle();

        // Stop write, then reset while TX still holds bytes.
        $display("[TB] stop test");
        tx_ready = 1'b1;
        writeTx(32'h0003_0004, 8'h00, 1'b1);
        idle();
        idle();
        checkOutput("program_done set", {31'h0, program_done}, 32'h1);
        tx_ready = 1'b0;
        writeTx(32'h0003_0000, 8'h11, 1'b0);
        writeTx(32'h0003_0000, 8'h22, 1'b0);
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
        checkOutput("tx_valid before reset", {31'h0, tx_valid}, 32'h1);
        checkOutput("tx_data before reset", {24'h0, tx_data}, 32'h11);
        rst_in = 1'b0;
        applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("mid-drain reset tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("mid-drain reset tx_data", {24'h0, tx_data}, 32'h0);
        checkOutput("mid-drain reset program_done", {31'h0, program_done}, 32'h0);
        checkOutput("mid-drain reset mem_din", {24'h0, mem_din}, 32'h0);
        checkOutput("mid-drain reset io_buffer_full", {31'h0, io_buffer_full}, 32'h0);
        rst_in   = 1'b1;
        tx_ready = 1'b1;
        repeat (5) idle();

        checkOutput("read queue empty", rdExpQ.size(), 32'h0);
        checkOutput("tx queue empty", txExpQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
